// File: rtl/sap2_pkg.sv
// Shared definitions for the SAP-2 program loader: widths, address limit
// and the loader state encoding.
package sap2_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 12;

    localparam logic [ADDR_W-1:0] MAX_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } load_state_t;

endpackage

// File: rtl/sap2_loader.sv
// SAP-2 program loader: takes a valid/ready stream of 12-bit words and
// writes them to consecutive CPU program addresses from 00h, then drops
// prog and pulses cpu_clr so the loaded program starts.
// Optional build macro SAP2_LOADER_CHECKSUM_EN: the s_last word becomes a
// checksum (not written); a nonzero 12-bit total of all accepted words
// sends the loader to ERR instead of CLEAR.
module sap2_loader
    import sap2_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CLR_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              prog,
    output logic [ADDR_W-1:0] a,
    output logic [WORD_W-1:0] d,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_CYCLES - 1);

    load_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_a, w_a_nxt;
    logic [WORD_W-1:0] r_d, w_d_nxt;
    logic              w_ready;
    logic              w_accept;
`ifdef SAP2_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_sum, w_sum_nxt;
    logic [WORD_W-1:0] w_sum_chk;
`else
    logic              r_last, w_last_nxt;
`endif

    // Ready only in the states that take words, and never while in reset.
    assign w_ready  = !clr && (r_state == ST_IDLE || r_state == ST_WAIT ||
                               r_state == ST_DONE);
    assign w_accept = s_valid && w_ready;
    assign s_ready  = w_ready;
    assign a        = r_a;
    assign d        = r_d;
`ifdef SAP2_LOADER_CHECKSUM_EN
    assign w_sum_chk = r_sum + s_data;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (clr) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath registers: hold/clear counter, address, data, stream info.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_d    <= '0;
`ifdef SAP2_LOADER_CHECKSUM_EN
            r_sum  <= '0;
`else
            r_last <= 1'b0;
`endif
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_a    <= w_a_nxt;
            r_d    <= w_d_nxt;
`ifdef SAP2_LOADER_CHECKSUM_EN
            r_sum  <= w_sum_nxt;
`else
            r_last <= w_last_nxt;
`endif
        end
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_d_nxt     = r_d;
`ifdef SAP2_LOADER_CHECKSUM_EN
        w_sum_nxt   = r_sum;
`else
        w_last_nxt  = r_last;
`endif
        prog    = 1'b0;
        cpu_clr = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;

        case (r_state)
            // IDLE and DONE both start a fresh load at 00h.
            ST_IDLE, ST_DONE: begin
                done = (r_state == ST_DONE);
                if (w_accept) begin
                    w_a_nxt = '0;
`ifdef SAP2_LOADER_CHECKSUM_EN
                    if (s_last) begin
                        // Lone checksum word: nothing to write, must be zero.
                        if (s_data == '0) begin
                            w_state_nxt = ST_CLEAR;
                            w_cnt_nxt   = CLR_LOAD;
                        end else begin
                            w_state_nxt = ST_ERR;
                        end
                    end else begin
                        w_d_nxt     = s_data;
                        w_sum_nxt   = s_data;
                        w_cnt_nxt   = HOLD_LOAD;
                        w_state_nxt = ST_HOLD;
                    end
`else
                    w_d_nxt     = s_data;
                    w_last_nxt  = s_last;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_state_nxt = ST_HOLD;
`endif
                end
            end
            ST_HOLD: begin
                prog = 1'b1;
                busy = 1'b1;
                if (r_cnt == '0) begin
`ifdef SAP2_LOADER_CHECKSUM_EN
                    w_state_nxt = ST_WAIT;
`else
                    if (r_last) begin
                        w_state_nxt = ST_CLEAR;
                        w_cnt_nxt   = CLR_LOAD;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_WAIT: begin
                prog = 1'b1;
                busy = 1'b1;
                if (w_accept) begin
`ifdef SAP2_LOADER_CHECKSUM_EN
                    if (s_last) begin
                        if (w_sum_chk == '0) begin
                            w_state_nxt = ST_CLEAR;
                            w_cnt_nxt   = CLR_LOAD;
                        end else begin
                            w_state_nxt = ST_ERR;
                        end
                    end else if (r_a == MAX_ADDR) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_a_nxt     = r_a + 1'b1;
                        w_d_nxt     = s_data;
                        w_sum_nxt   = w_sum_chk;
                        w_cnt_nxt   = HOLD_LOAD;
                        w_state_nxt = ST_HOLD;
                    end
`else
                    // Address space exhausted: abort without writing.
                    if (r_a == MAX_ADDR) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_a_nxt     = r_a + 1'b1;
                        w_d_nxt     = s_data;
                        w_last_nxt  = s_last;
                        w_cnt_nxt   = HOLD_LOAD;
                        w_state_nxt = ST_HOLD;
                    end
`endif
                end
            end
            ST_CLEAR: begin
                cpu_clr = 1'b1;
                busy    = 1'b1;
                if (r_cnt == '0) w_state_nxt = ST_DONE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sap2_loader.sv
// Scoreboard bench for sap2_loader: stimulus pushes expected write/clear/
// error events, a negedge monitor pops and compares them as the DUT shows them.
module tb_sap2_loader;

    localparam int HOLD = 2;
    localparam int CLRC = 2;
    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_CLR = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  a;
        logic [11:0] d;
    } exp_t;

    logic        clk;
    logic        clr;
    logic        s_valid;
    logic [11:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        prog;
    logic [7:0]  a;
    logic [11:0] d;
    logic        cpu_clr;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    sap2_loader #(.HOLD_CYCLES(HOLD), .CLR_CYCLES(CLRC)) dut (
        .clk(clk), .clr(clr), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .prog(prog), .a(a), .d(d),
        .cpu_clr(cpu_clr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] ea, input logic [11:0] ed);
        exp_t e;
        e.kind = k; e.a = ea; e.d = ed;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input logic [1:0] k, input logic [7:0] ga, input logic [11:0] gd);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d a=%h d=%h want none", k, ga, gd);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == K_WR && (e.a != ga || e.d != gd))) begin
                bad++;
                $display("FAIL event got kind=%0d a=%h d=%h want kind=%0d a=%h d=%h",
                         k, ga, gd, e.kind, e.a, e.d);
            end
        end
    endtask

    // Monitor: detects write starts, hold widths, clear pulses and error entry.
    logic        p_prog = 0, p_cpu_clr = 0, p_err = 0, p_acc = 0;
    logic [7:0]  p_a = 0;
    logic [11:0] p_d = 0;
    int          hold_run = 0, clr_run = 0;
    always @(negedge clk) begin
        if (prog && (!p_prog || a != p_a)) got_ev(K_WR, a, d);
        if (prog && p_prog && !p_acc) begin
            total++;
            if (a != p_a || d != p_d) begin
                bad++;
                $display("FAIL ad_stable got a=%h d=%h want a=%h d=%h", a, d, p_a, p_d);
            end
        end
        if (clr) hold_run = 0;
        else if (prog && !s_ready) hold_run++;
        else if (hold_run > 0) begin
            check("hold_len", hold_run, HOLD);
            hold_run = 0;
        end
        if (cpu_clr) clr_run++;
        else if (p_cpu_clr) begin
            got_ev(K_CLR, 8'h0, 12'h0);
            check("clr_len", clr_run, CLRC);
            check("done_at_clr_fall", done, 1);
            clr_run = 0;
        end
        if (err && !p_err) begin
            got_ev(K_ERR, 8'h0, 12'h0);
            check("err_prog", prog, 0);
            check("err_ready", s_ready, 0);
        end
        p_prog = prog; p_cpu_clr = cpu_clr; p_err = err;
        p_a = a; p_d = d; p_acc = s_valid && s_ready;
    end

    // One handshake; leaves junk on data/last afterwards to show it is ignored.
    task automatic send(input logic [11:0] w, input logic last);
        int t;
        t = 0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = w; s_last = last;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL handshake_timeout got ready=0 want ready=1");
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 12'hABC; s_last = 1'b1;
    endtask

    task automatic wait_flag(input string nm, input bit want_err);
        int t;
        t = 0;
        while (!(done || err) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(nm, want_err ? err : done, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    logic [11:0] vec [8];

    initial begin
        vec = '{12'h004, 12'hF20, 12'hF40, 12'h905, 12'hEFF, 12'hF20, 12'hFE0, 12'hFF0};
        clr = 1'b1; s_valid = 1'b0; s_data = 12'h0; s_last = 1'b0;

        @(negedge clk);
        check("rst_ready", s_ready, 0);
        check("rst_prog", prog, 0);
        check("rst_a", a, 0);
        check("rst_d", d, 0);
        check("rst_cpu_clr", cpu_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("idle_ready", s_ready, 1);

`ifdef SAP2_LOADER_CHECKSUM_EN
        push(K_CLR, 0, 0);
        send(12'h000, 1'b1);
        wait_flag("ck_single_done", 0);

        push(K_WR, 8'h00, 12'h001);
        push(K_WR, 8'h01, 12'h002);
        push(K_CLR, 0, 0);
        send(12'h001, 1'b0);
        check("ck_restart_done", done, 0);
        send(12'h002, 1'b0);
        send(12'hFFD, 1'b1);
        wait_flag("ck_good_done", 0);

        push(K_WR, 8'h00, 12'h001);
        push(K_WR, 8'h01, 12'h002);
        push(K_ERR, 0, 0);
        send(12'h001, 1'b0);
        send(12'h002, 1'b0);
        send(12'hFFE, 1'b1);
        wait_flag("ck_bad_err", 1);
        repeat (4) begin
            @(negedge clk);
            check("ck_bad_cpu_clr", cpu_clr, 0);
        end
        do_reset();
        check("ck_err_cleared", err, 0);
`else
        // Back-to-back eight-word program.
        for (int i = 0; i < 8; i++) begin
            push(K_WR, 8'(i), vec[i]);
            if (i == 7) push(K_CLR, 0, 0);
            send(vec[i], i == 7);
        end
        wait_flag("prog1_done", 0);
        check("prog1_busy", busy, 0);

        // Same program with idle gaps between words.
        for (int i = 0; i < 8; i++) begin
            push(K_WR, 8'(i), vec[i]);
            if (i == 7) push(K_CLR, 0, 0);
            send(vec[i], i == 7);
            if (i == 0) begin
                check("restart_done_low", done, 0);
                check("restart_busy", busy, 1);
            end
            if (i < 7) begin
                repeat (4) begin
                    @(negedge clk);
                    check("gap_prog", prog, 1);
                end
            end
        end
        wait_flag("prog2_done", 0);

        // Single-word program straight from DONE.
        push(K_WR, 8'h00, 12'h0FF);
        push(K_CLR, 0, 0);
        send(12'h0FF, 1'b1);
        check("single_done_low", done, 0);
        wait_flag("single_done", 0);

        // clr during the hold of the third word.
        push(K_WR, 8'h00, 12'h111);
        push(K_WR, 8'h01, 12'h222);
        push(K_WR, 8'h02, 12'h333);
        send(12'h111, 1'b0);
        send(12'h222, 1'b0);
        send(12'h333, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        check("abort_prog", prog, 0);
        check("abort_a", a, 0);
        check("abort_busy", busy, 0);
        check("abort_cpu_clr", cpu_clr, 0);
        clr = 1'b0;
        push(K_WR, 8'h00, 12'h0AB);
        push(K_WR, 8'h01, 12'h0CD);
        push(K_CLR, 0, 0);
        send(12'h0AB, 1'b0);
        send(12'h0CD, 1'b1);
        wait_flag("reload_done", 0);

        // 257 non-last words overflow the address space.
        for (int i = 0; i < 257; i++) begin
            if (i < 256) push(K_WR, 8'(i), 12'(i) ^ 12'h5A5);
            else         push(K_ERR, 0, 0);
            send(12'(i) ^ 12'h5A5, 1'b0);
        end
        repeat (4) begin
            @(negedge clk);
            check("ovf_err", err, 1);
            check("ovf_ready", s_ready, 0);
            check("ovf_cpu_clr", cpu_clr, 0);
        end
        do_reset();
        check("ovf_err_cleared", err, 0);
`endif

        begin
            int t;
            t = 0;
            while (exp_q.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("events_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
